// File: rtl/mult_pkg.sv
// Shared types and elaboration helpers for the chunked sequential multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Number of CHUNK-wide slices per operand.
    function automatic int nch(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic bit width_ok(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

    // Slice-index width; never zero so the NCH = 1 case still has a legal vector.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunk_mult.sv
// Combinational CHUNK x CHUNK unsigned multiply producing a 2*CHUNK-bit partial product.
module chunk_mult #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0]   i_a,
    input  logic [CHUNK-1:0]   i_b,
    output logic [2*CHUNK-1:0] o_p
);

    assign o_p = {{CHUNK{1'b0}}, i_a} * {{CHUNK{1'b0}}, i_b};

endmodule

// File: rtl/seq_chunk_mult.sv
// Iterative WIDTH x WIDTH multiplier: one CHUNK x CHUNK partial product per cycle,
// shifted and accumulated on sign-stripped magnitudes, sign restored in FIX.
module seq_chunk_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               busy
);

    localparam int NCH = nch(WIDTH, CHUNK);
    localparam int IW  = idx_w(NCH);
    localparam int PW  = 2 * WIDTH;
    localparam logic [IW-1:0] LAST = IW'(NCH - 1);

    if (!width_ok(WIDTH, CHUNK)) begin : g_bad_width
        $error("seq_chunk_mult: WIDTH must be a positive multiple of CHUNK");
    end

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a_mag;
    logic [WIDTH-1:0] r_b_mag;
    logic             r_neg;
    logic [IW-1:0]    r_i;
    logic [IW-1:0]    r_j;
    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_result;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_accept;
    logic [CHUNK-1:0]   w_a_sl [NCH];
    logic [CHUNK-1:0]   w_b_sl [NCH];
    logic [CHUNK-1:0]   w_a_chunk;
    logic [CHUNK-1:0]   w_b_chunk;
    logic [2*CHUNK-1:0] w_pp;
    logic [PW-1:0]      w_term;
    int unsigned        w_shift;

    // Two's-complement of the most negative value is itself, which is the correct unsigned magnitude.
    assign w_a_mag  = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign w_b_mag  = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    assign w_accept = in_valid && in_ready;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_slice
        assign w_a_sl[gi] = r_a_mag[gi*CHUNK +: CHUNK];
        assign w_b_sl[gi] = r_b_mag[gi*CHUNK +: CHUNK];
    end

    assign w_a_chunk = w_a_sl[r_i];
    assign w_b_chunk = w_b_sl[r_j];

    chunk_mult #(.CHUNK(CHUNK)) u_chunk_mult (
        .i_a (w_a_chunk),
        .i_b (w_b_chunk),
        .o_p (w_pp)
    );

    always_comb begin
        w_shift = (32'(r_i) + 32'(r_j)) * 32'(CHUNK);
        w_term  = PW'(w_pp) << w_shift;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) w_state_next = MUL;
            end
            MUL: begin
                if (r_i == LAST && r_j == LAST) w_state_next = FIX;
            end
            FIX: w_state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_mag  <= '0;
            r_b_mag  <= '0;
            r_neg    <= 1'b0;
            r_i      <= '0;
            r_j      <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a_mag <= w_a_mag;
                        r_b_mag <= w_b_mag;
                        r_neg   <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_acc   <= '0;
                        r_i     <= '0;
                        r_j     <= '0;
                    end
                end
                MUL: begin
                    r_acc <= r_acc + w_term;
                    if (r_j == LAST) begin
                        r_j <= '0;
                        if (r_i != LAST) r_i <= r_i + IW'(1);
                    end else begin
                        r_j <= r_j + IW'(1);
                    end
                end
                FIX: begin
                    r_result <= r_neg ? (~r_acc + PW'(1)) : r_acc;
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;

endmodule

// File: doc/seq_chunk_mult.md
Name: seq_chunk_mult

Overview:
Parametrised iterative integer multiplier. It computes a WIDTH x WIDTH -> 2*WIDTH product by multiplying one CHUNK x CHUNK partial product per clock and accumulating the shifted results. It trades the area of a full parallel tree for NCH*NCH cycles of latency, where NCH = WIDTH/CHUNK. It adds a signed/unsigned mode and valid/ready handshakes on both the input and output sides, and sits in the FPM datapath wherever a low-area mantissa or integer multiply is needed.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
CHUNK, 8, partial-product slice width; one CHUNK x CHUNK multiply per cycle.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst_n  input  1  synchronous active-low reset.
in_valid  input  1  operands and mode are valid.
in_ready  output  1  block can accept a new operation.
a  input  WIDTH  multiplicand.
b  input  WIDTH  multiplier.
is_signed  input  1  1 = two's-complement operands, 0 = unsigned.
out_valid  output  1  result is valid.
out_ready  input  1  consumer accepts the result.
result  output  2*WIDTH  product.
busy  output  1  an operation is in flight (state is not IDLE).

Behaviour:
- Reset (rst_n = 0 at a clock edge): state goes to IDLE; accumulator, result, chunk indices i/j and sign flag clear to 0; out_valid = 0, busy = 0, in_ready = 1 the cycle after reset. Reset mid-operation aborts the operation and discards it; no out_valid is produced.
- in_ready = 1 only in IDLE. Accept happens on the edge where in_valid & in_ready. At accept:
  - Magnitudes are latched: |a| and |b| when is_signed, otherwise raw a and b.
  - neg = is_signed & (a[MSB] ^ b[MSB]) is latched.
  - Accumulator clears to 0; i = j = 0.
  - |-2^(WIDTH-1)| is held as the unsigned WIDTH-bit value 2^(WIDTH-1); no overflow.
- States:
  - IDLE: on accept -> MUL.
  - MUL: each cycle, acc += (A_i * B_j) << ((i+j)*CHUNK), where A_i and B_j are CHUNK-bit slices of the latched magnitudes.
    - j increments; when j wraps from NCH-1 to 0, i increments.
    - After the step with i = j = NCH-1 -> FIX. MUL lasts exactly NCH*NCH cycles.
  - FIX: result <= neg ? -acc (2*WIDTH-bit two's complement) : acc; -> DONE.
  - DONE: out_valid = 1. result is held stable while out_valid & !out_ready. On out_valid & out_ready -> IDLE.
- Latency: out_valid is first high NCH*NCH + 1 edges after the accept edge (17 for the defaults).
- Throughput: there is no same-cycle accept in DONE. With out_ready tied high, back-to-back operations issue every NCH*NCH + 3 cycles.
- Widths:
  - The accumulator is 2*WIDTH bits and the sum never exceeds the true product, so no overflow is possible.
  - Each partial product is 2*CHUNK bits, zero-extended before shifting.
- Inputs a, b and is_signed are ignored outside the accept edge. Changing them during MUL has no effect.
- result keeps the last product after the DONE->IDLE transition, until the next FIX or a reset.
- Degenerate case NCH = 1 (CHUNK = WIDTH): MUL lasts 1 cycle.

Decomposition:
- Package mult_pkg holds:
  - the state enum {IDLE, MUL, FIX, DONE};
  - function nch(WIDTH, CHUNK);
  - an elaboration-time check that WIDTH % CHUNK == 0.
- Sub-module chunk_mult: combinational CHUNK x CHUNK -> 2*CHUNK unsigned multiply, instantiated once. The top level contains the FSM, slice muxes, shifter and accumulator.

Test Plan:
- Reset then idle: hold rst_n = 0 for 2 cycles -> in_ready = 1, out_valid = 0, busy = 0, result = 0.
- Unsigned: a = 0xFFFFFFFF, b = 0xFFFFFFFF, is_signed = 0 -> result = 0xFFFFFFFE00000001, out_valid exactly 17 cycles after accept.
- Signed: a = -3 (0xFFFFFFFD), b = 7, is_signed = 1 -> result = 0xFFFFFFFFFFFFFFEB (-21).
- Signed extremes: a = b = 0x80000000, is_signed = 1 -> result = 0x4000000000000000.
- Output backpressure: hold out_ready = 0 for 5 cycles after out_valid -> result stays stable and in_ready stays 0. After the release, one handshake, then IDLE.
- Mid-operation reset: accept 1234 x 5678, then assert rst_n = 0 on MUL cycle 6 -> no out_valid. A following 2 x 3 operation returns 6.
- Parameter sweep (optional): WIDTH = 16, CHUNK = 4 with random operands against a reference model; latency is 17; signed and unsigned both checked.
